// File: rtl/risc16_pkg.sv
// risc16_pkg: shared RiSC-16 definitions.
//   - opcode constants (bits [15:13] of the instruction word)
//   - instruction field bit positions
//   - fetch-stage state encoding (if_state_t)
//   - immediate-forming helpers used by the field decoder
package risc16_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 16;

  // Opcodes
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_LUI  = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;

  // Field bit positions
  localparam int unsigned OP_MSB    = 15;
  localparam int unsigned OP_LSB    = 13;
  localparam int unsigned RA_MSB    = 12;
  localparam int unsigned RA_LSB    = 10;
  localparam int unsigned RB_MSB    = 9;
  localparam int unsigned RB_LSB    = 7;
  localparam int unsigned RC_MSB    = 2;
  localparam int unsigned RC_LSB    = 0;
  localparam int unsigned SIMM_MSB  = 6;
  localparam int unsigned LUI_MSB   = 9;
  localparam int unsigned LUI_SHIFT = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } if_state_t;

  // 7-bit signed immediate to a full word.
  function automatic logic [WORD_W-1:0] sext7(input logic [SIMM_MSB:0] v);
    return {{(WORD_W-SIMM_MSB-1){v[SIMM_MSB]}}, v};
  endfunction

  // 10-bit upper immediate placed in the top of the word.
  function automatic logic [WORD_W-1:0] lui_imm(input logic [LUI_MSB:0] v);
    return {v, {LUI_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/risc16_field_decode.sv
// risc16_field_decode: purely combinational split of a RiSC-16 instruction
// word into its fields. Shared by the fetch stage and the control unit.
//   instr  in  16  instruction word
//   op     out 3   opcode [15:13]
//   ra     out 3   [12:10]
//   rb     out 3   [9:7]
//   rc     out 3   [2:0]
//   simm   out 16  [6:0] sign-extended
//   lui    out 16  {[9:0], 6'b0}
module risc16_field_decode
  import risc16_pkg::*;
(
  input  logic [WORD_W-1:0] instr,
  output logic [2:0]        op,
  output logic [2:0]        ra,
  output logic [2:0]        rb,
  output logic [2:0]        rc,
  output logic [WORD_W-1:0] simm,
  output logic [WORD_W-1:0] lui
);

  assign op   = instr[OP_MSB:OP_LSB];
  assign ra   = instr[RA_MSB:RA_LSB];
  assign rb   = instr[RB_MSB:RB_LSB];
  assign rc   = instr[RC_MSB:RC_LSB];
  assign simm = sext7(instr[SIMM_MSB:0]);
  assign lui  = lui_imm(instr[LUI_MSB:0]);

endmodule

// File: rtl/if_stage.sv
// if_stage: RiSC-16 instruction fetch stage.
// Fetches one word at a time from instruction memory (req/gnt/rvalid),
// holds it in the instruction register and offers it downstream with its
// PC and decoded fields over valid/ready. pc_advance pulses on acceptance.
//   clk, rst_n        clock, synchronous active-low reset
//   pc_in             current PC
//   pc_advance        high in the cycle an instruction is accepted
//   flush             PC redirect; discard in-flight work
//   imem_req/addr     fetch request, address stable while req is high
//   imem_gnt          request accepted
//   imem_rvalid/rdata read response
//   out_valid/ready   downstream handshake
//   out_instr/out_pc  instruction register and its fetch address
//   out_op..out_lui   decoded fields of out_instr
//   proto_err         sticky: rvalid seen outside WAIT
module if_stage
  import risc16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_advance,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [2:0]        out_op,
  output logic [2:0]        out_ra,
  output logic [2:0]        out_rb,
  output logic [2:0]        out_rc,
  output logic [WORD_W-1:0] out_simm,
  output logic [WORD_W-1:0] out_lui,
  output logic              proto_err
);

  if_state_t         state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              req_first_q, req_first_d;
  logic              drop_q, drop_d;
  logic [WORD_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic              proto_err_q, proto_err_d;

  // The PC register updates on the same edge that leaves HOLD/WAIT, so the
  // fresh pc_in is only visible during the first REQ cycle. The address is
  // taken straight from pc_in in that cycle and registered for the rest of
  // the request, keeping imem_addr stable until grant.
  assign fetch_pc_d = req_first_q ? pc_in : fetch_pc_q;
  assign imem_addr  = fetch_pc_d;

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    proto_err_d = proto_err_q | (imem_rvalid & (state_q != WAIT));
    imem_req    = 1'b0;
    out_valid   = 1'b0;
    pc_advance  = 1'b0;

    unique case (state_q)
      IDLE: state_d = REQ;

      REQ: begin
        // A granted-but-flushed request still completes on the bus; the
        // drop flag makes WAIT swallow its data.
        imem_req = 1'b1;
        if (flush)    drop_d  = 1'b1;
        if (imem_gnt) state_d = WAIT;
      end

      WAIT: begin
        if (imem_rvalid) begin
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            out_instr_d = imem_rdata;
            out_pc_d    = fetch_pc_q;
            state_d     = HOLD;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end

      HOLD: begin
        out_valid = 1'b1;
        if (flush) begin
          state_d = REQ;
        end else if (out_ready) begin
          pc_advance = 1'b1;
          state_d    = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign req_first_d = (state_d == REQ) && (state_q != REQ);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= '0;
      req_first_q <= 1'b0;
      drop_q      <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_first_q <= req_first_d;
      drop_q      <= drop_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign proto_err = proto_err_q;

  risc16_field_decode u_dec (
    .instr (out_instr_q),
    .op    (out_op),
    .ra    (out_ra),
    .rb    (out_rb),
    .rc    (out_rc),
    .simm  (out_simm),
    .lui   (out_lui)
  );

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scripted scenarios for if_stage. Expected {pc, instr} pairs
// are queued when a good read response is driven and popped when the stage
// presents out_valid.
module tb_if_stage;
  import risc16_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_in;
  logic        pc_advance;
  logic        flush;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [2:0]  out_op, out_ra, out_rb, out_rc;
  logic [15:0] out_simm, out_lui;
  logic        proto_err;

  if_stage dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_advance(pc_advance),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_op(out_op), .out_ra(out_ra), .out_rb(out_rb),
    .out_rc(out_rc), .out_simm(out_simm), .out_lui(out_lui),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] pc; logic [15:0] instr; } exp_t;
  exp_t sb[$];
  exp_t e;

  int checks = 0;
  int errors = 0;
  int adv_cnt = 0;
  int a0;

  always @(posedge clk) if (pc_advance) adv_cnt++;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic pop_exp;
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL sb_empty out_instr=%h expected a queued entry", out_instr);
      e.pc = 16'hxxxx; e.instr = 16'hxxxx;
    end else e = sb.pop_front();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; pc_in = 16'h0000; flush = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 16'h0000; out_ready = 1'b0;
    tick; tick;
    rst_n = 1'b1; #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    checks++; if (pc_advance !== 1'b0) begin errors++; $display("FAIL rst_adv got %b exp 0", pc_advance); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_perr got %b exp 0", proto_err); end
    checks++; if (out_instr !== 16'h0000) begin errors++; $display("FAIL rst_instr got %h exp 0000", out_instr); end
    checks++; if (out_pc !== 16'h0000) begin errors++; $display("FAIL rst_pc got %h exp 0000", out_pc); end
  endtask

  task automatic test_basic;
    a0 = adv_cnt;
    tick;                                   // cycle 1: REQ
    imem_gnt = 1'b1; #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL basic_req got %b exp 1", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL basic_addr got %h exp 0000", imem_addr); end
    tick;                                   // cycle 2: WAIT
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'h2485;
    sb.push_back('{pc: 16'h0000, instr: 16'h2485}); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", out_valid); end
    tick;                                   // cycle 3: HOLD
    imem_rvalid = 1'b0; out_ready = 1'b1; #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
    pop_exp;
    checks++; if (out_pc !== e.pc) begin errors++; $display("FAIL basic_pc got %h exp %h", out_pc, e.pc); end
    checks++; if (out_instr !== e.instr) begin errors++; $display("FAIL basic_instr got %h exp %h", out_instr, e.instr); end
    checks++; if (out_op !== OP_ADDI) begin errors++; $display("FAIL basic_op got %0d exp 1", out_op); end
    checks++; if (out_ra !== 3'd1) begin errors++; $display("FAIL basic_ra got %0d exp 1", out_ra); end
    checks++; if (out_rb !== 3'd1) begin errors++; $display("FAIL basic_rb got %0d exp 1", out_rb); end
    checks++; if (out_simm !== 16'h0005) begin errors++; $display("FAIL basic_simm got %h exp 0005", out_simm); end
    checks++; if (pc_advance !== 1'b1) begin errors++; $display("FAIL basic_adv got %b exp 1", pc_advance); end
    tick;                                   // REQ, PC moved
    out_ready = 1'b0; pc_in = 16'h0001; #1;
    checks++; if (adv_cnt !== a0 + 1) begin errors++; $display("FAIL basic_adv_cnt got %0d exp %0d", adv_cnt, a0 + 1); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b exp 0", out_valid); end
  endtask

  task automatic test_decode;
    imem_gnt = 1'b1; tick;
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'hC07F;
    sb.push_back('{pc: 16'h0001, instr: 16'hC07F}); tick;
    imem_rvalid = 1'b0; out_ready = 1'b1; #1;
    pop_exp;
    checks++; if (out_instr !== e.instr) begin errors++; $display("FAIL dec_beq_instr got %h exp %h", out_instr, e.instr); end
    checks++; if (out_op !== OP_BEQ) begin errors++; $display("FAIL dec_beq_op got %0d exp 6", out_op); end
    checks++; if (out_simm !== 16'hFFFF) begin errors++; $display("FAIL dec_beq_simm got %h exp FFFF", out_simm); end
    tick;
    pc_in = 16'hFFFF; imem_gnt = 1'b1; #1;
    checks++; if (imem_addr !== 16'hFFFF) begin errors++; $display("FAIL dec_addr_ffff got %h exp FFFF", imem_addr); end
    tick;
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'h63FF;
    sb.push_back('{pc: 16'hFFFF, instr: 16'h63FF}); tick;
    imem_rvalid = 1'b0; #1;
    pop_exp;
    checks++; if (out_pc !== e.pc) begin errors++; $display("FAIL dec_lui_pc got %h exp %h", out_pc, e.pc); end
    checks++; if (out_op !== OP_LUI) begin errors++; $display("FAIL dec_lui_op got %0d exp 3", out_op); end
    checks++; if (out_lui !== 16'hFFC0) begin errors++; $display("FAIL dec_lui_imm got %h exp FFC0", out_lui); end
    checks++; if (out_rb !== 3'd7 || out_rc !== 3'd7) begin errors++; $display("FAIL dec_lui_rbrc got %0d/%0d exp 7/7", out_rb, out_rc); end
    tick;
    out_ready = 1'b0; pc_in = 16'h0000;     // wraps past FFFF
  endtask

  task automatic test_stall_grant;
    pc_in = 16'h0100; #1;
    checks++; if (imem_addr !== 16'h0100) begin errors++; $display("FAIL stall_addr0 got %h exp 0100", imem_addr); end
    for (int i = 0; i < 4; i++) begin
      tick;
      pc_in = pc_in + 16'h0011; #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin
        errors++; $display("FAIL stall_hold%0d req=%b addr=%h exp 1/0100", i, imem_req, imem_addr);
      end
    end
    imem_gnt = 1'b1; tick;
    imem_gnt = 1'b0; #1;
    checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_wait req=%b valid=%b exp 0/0", imem_req, out_valid); end
    tick;
    imem_rvalid = 1'b1; imem_rdata = 16'hA123;
    sb.push_back('{pc: 16'h0100, instr: 16'hA123}); tick;
    imem_rvalid = 1'b0; #1;
    pop_exp;
    checks++; if (out_pc !== e.pc || out_instr !== e.instr) begin errors++; $display("FAIL stall_data got %h/%h exp %h/%h", out_pc, out_instr, e.pc, e.instr); end
    a0 = adv_cnt;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_instr !== 16'hA123 || pc_advance !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d valid=%b instr=%h adv=%b exp 1/A123/0", i, out_valid, out_instr, pc_advance);
      end
      tick;
    end
    out_ready = 1'b1; #1;
    checks++; if (pc_advance !== 1'b1) begin errors++; $display("FAIL bp_adv got %b exp 1", pc_advance); end
    tick;
    out_ready = 1'b0; pc_in = 16'h0200; #1;
    checks++; if (adv_cnt !== a0 + 1) begin errors++; $display("FAIL bp_adv_cnt got %0d exp %0d", adv_cnt, a0 + 1); end
  endtask

  task automatic test_flush_wait;
    imem_gnt = 1'b1; #1;
    checks++; if (imem_addr !== 16'h0200) begin errors++; $display("FAIL fw_addr got %h exp 0200", imem_addr); end
    tick;                                   // WAIT
    imem_gnt = 1'b0; flush = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fw_valid0 got %b exp 0", out_valid); end
    tick;
    flush = 1'b0; pc_in = 16'h0300; imem_rvalid = 1'b1; imem_rdata = 16'hDEAD; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fw_valid1 got %b exp 0", out_valid); end
    tick;                                   // back to REQ
    imem_rvalid = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fw_stale_valid got %b exp 0", out_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0300) begin errors++; $display("FAIL fw_refetch req=%b addr=%h exp 1/0300", imem_req, imem_addr); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL fw_perr got %b exp 0", proto_err); end
    imem_gnt = 1'b1; tick;
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'h1234;
    sb.push_back('{pc: 16'h0300, instr: 16'h1234}); tick;
    imem_rvalid = 1'b0; out_ready = 1'b1; #1;
    pop_exp;
    checks++; if (out_pc !== e.pc || out_instr !== e.instr) begin errors++; $display("FAIL fw_new got %h/%h exp %h/%h", out_pc, out_instr, e.pc, e.instr); end
    tick;
    out_ready = 1'b0; pc_in = 16'h0400;
  endtask

  task automatic test_flush_hold;
    imem_gnt = 1'b1; tick;
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'h5555;
    sb.push_back('{pc: 16'h0400, instr: 16'h5555}); tick;
    imem_rvalid = 1'b0; out_ready = 1'b1; flush = 1'b1; #1;
    pop_exp;
    checks++; if (out_valid !== 1'b1 || out_instr !== e.instr) begin errors++; $display("FAIL fh_present valid=%b instr=%h exp 1/%h", out_valid, out_instr, e.instr); end
    checks++; if (pc_advance !== 1'b0) begin errors++; $display("FAIL fh_adv got %b exp 0", pc_advance); end
    a0 = adv_cnt;
    tick;
    flush = 1'b0; out_ready = 1'b0; pc_in = 16'h0500; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fh_valid got %b exp 0", out_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0500) begin errors++; $display("FAIL fh_refetch req=%b addr=%h exp 1/0500", imem_req, imem_addr); end
    checks++; if (adv_cnt !== a0) begin errors++; $display("FAIL fh_adv_cnt got %0d exp %0d", adv_cnt, a0); end
  endtask

  task automatic test_proto_err;
    imem_gnt = 1'b1; tick;
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'h0007;
    sb.push_back('{pc: 16'h0500, instr: 16'h0007}); tick;
    imem_rdata = 16'hBEEF; #1;               // spurious rvalid in HOLD
    pop_exp;
    checks++; if (out_instr !== e.instr || out_pc !== e.pc) begin errors++; $display("FAIL pe_data got %h/%h exp %h/%h", out_pc, out_instr, e.pc, e.instr); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL pe_early got %b exp 0", proto_err); end
    tick;
    imem_rvalid = 1'b0; #1;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL pe_set got %b exp 1", proto_err); end
    checks++; if (out_valid !== 1'b1 || out_instr !== 16'h0007) begin errors++; $display("FAIL pe_hold valid=%b instr=%h exp 1/0007", out_valid, out_instr); end
    out_ready = 1'b1; tick;
    out_ready = 1'b0; pc_in = 16'h0600;
  endtask

  task automatic test_reset_mid_fetch;
    imem_gnt = 1'b1; tick;                  // WAIT
    imem_gnt = 1'b0; rst_n = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'h7777; tick;
    rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 16'hABCD; #1;   // IDLE, late response
    checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0 || pc_advance !== 1'b0) begin
      errors++; $display("FAIL rmf_ctrl req=%b valid=%b adv=%b exp 0/0/0", imem_req, out_valid, pc_advance);
    end
    checks++; if (out_instr !== 16'h0000 || out_pc !== 16'h0000) begin errors++; $display("FAIL rmf_regs got %h/%h exp 0000/0000", out_pc, out_instr); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rmf_perr_clr got %b exp 0", proto_err); end
    tick;
    imem_rvalid = 1'b0; #1;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL rmf_late_perr got %b exp 1", proto_err); end
    checks++; if (imem_req !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rmf_req req=%b valid=%b exp 1/0", imem_req, out_valid); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", sb.size()); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_decode;
    test_stall_grant;
    test_flush_wait;
    test_flush_hold;
    test_proto_err;
    test_reset_mid_fetch;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
